pwm_shadow_bank: RTL and testbench

- Parametrised bank of N_CH double-buffered (staging/active) registers for PWM compare and period values.
- Software-side writes go to staging registers. Channels are marked pending and committed atomically to the active outputs on a mask_event strobe once armed.
- Sits between the AXI register file and the PWM counters/comparators. Guarantees glitch-free, simultaneous update of all channels at a period boundary.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_shadow_channel.sv | 36 +++
 rtl/pwm_shadow_bank.sv | 135 +++++++++++++
 tb/tb_pwm_shadow_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM types and constants: shadow-bank FSM states and sizing helpers.
package pwm_pkg;

  localparam int unsigned SB_MAX_CH        = 16;
  localparam int unsigned SB_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_STAGING,
    SB_ARMED
  } shadow_state_t;

  // Channel-index width; a one-channel bank still gets a 1-bit index.
  function automatic int unsigned sb_ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_shadow_channel.sv
// One shadow channel: staging register, active register and pending flag.
// load captures wr_data into staging and marks the channel pending;
// commit copies staging to active only when the channel is pending.
module pwm_shadow_channel #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             commit,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] staging,
  output logic [WIDTH-1:0] active,
  output logic             pending
);

  // Staging/active/pending update; load and commit never coincide (ARMED blocks writes).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staging <= RESET_VAL;
      active  <= RESET_VAL;
      pending <= 1'b0;
    end else begin
      if (load) begin
        staging <= wr_data;
        pending <= 1'b1;
      end
      if (commit && pending) begin
        active  <= staging;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_shadow_bank.sv
// Double-buffered PWM compare/period bank. Software writes land in staging
// registers; once armed, all pending channels move to their active outputs
// together on the next unlocked mask_event.
// Optional readback port of the staging registers: define PWM_SHADOW_READBACK_EN.
// N_CH is expected in 1..SB_MAX_CH.
module pwm_shadow_bank
  import pwm_pkg::*;
#(
  parameter int unsigned      N_CH      = 4,
  parameter int unsigned      WIDTH     = SB_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CH_W      = sb_ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ready,
  input  logic                  arm,
  input  logic                  mask_event,
  input  logic                  lock,
  output logic [N_CH*WIDTH-1:0] active_out,
  output logic [N_CH-1:0]       pending,
  output logic                  update_done,
`ifdef PWM_SHADOW_READBACK_EN
  input  logic [CH_W-1:0]       rd_ch,
  output logic [WIDTH-1:0]      rd_data,
`endif
  output logic                  wr_err
);

  shadow_state_t    state;
  shadow_state_t    state_nxt;
  logic             commit;
  logic             wr_accept;
  logic             wr_in_range;
  logic [N_CH-1:0]  load_vec;
  logic [WIDTH-1:0] active_arr [N_CH];
`ifdef PWM_SHADOW_READBACK_EN
  logic [WIDTH-1:0] staging_arr [N_CH];
  logic [WIDTH-1:0] rd_sel;
`else
  logic [WIDTH-1:0] staging_unused [N_CH];
`endif

  assign wr_ready    = (state != SB_ARMED);
  assign wr_accept   = wr_en && wr_ready;
  assign wr_in_range = ({1'b0, wr_ch} < (CH_W + 1)'(N_CH));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and commit strobe.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      SB_IDLE: begin
        if (wr_accept && wr_in_range) state_nxt = SB_STAGING;
      end
      SB_STAGING: begin
        if (arm) state_nxt = SB_ARMED;
      end
      SB_ARMED: begin
        if (mask_event && !lock) begin
          commit    = 1'b1;
          state_nxt = SB_IDLE;
        end
      end
      default: state_nxt = SB_IDLE;
    endcase
  end

  // Commit-done pulse and sticky out-of-range write error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_done <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      update_done <= commit;
      if (wr_accept && !wr_in_range) wr_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load_vec[i] = wr_accept && (wr_ch == CH_W'(i));

    pwm_shadow_channel #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (load_vec[i]),
      .commit  (commit),
      .wr_data (wr_data),
`ifdef PWM_SHADOW_READBACK_EN
      .staging (staging_arr[i]),
`else
      .staging (staging_unused[i]),
`endif
      .active  (active_arr[i]),
      .pending (pending[i])
    );

    assign active_out[i*WIDTH +: WIDTH] = active_arr[i];
  end

`ifdef PWM_SHADOW_READBACK_EN
  // Staging select; indices with no channel behind them read as zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_sel = staging_arr[i];
    end
  end

  // Registered readback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// Self-checking bench for pwm_shadow_bank: a 4-channel instance checked every
// cycle against a behavioural model, plus a 3-channel instance for the
// out-of-range and reset-while-armed cases.
module tb_pwm_shadow_bank;

  localparam int unsigned N4 = 4;
  localparam int unsigned N3 = 3;
  localparam int unsigned W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic            rst4, wr_en4, arm4, mask4, lock4;
  logic [1:0]      wr_ch4;
  logic [W-1:0]    wr_data4;
  logic            wr_ready4, done4, err4;
  logic [N4*W-1:0] active4;
  logic [N4-1:0]   pending4;
  // 3-channel instance
  logic            rst3, wr_en3, arm3, mask3, lock3;
  logic [1:0]      wr_ch3;
  logic [W-1:0]    wr_data3;
  logic            wr_ready3, done3, err3;
  logic [N3*W-1:0] active3;
  logic [N3-1:0]   pending3;
`ifdef PWM_SHADOW_READBACK_EN
  logic [1:0]      rd_ch4, rd_ch3;
  logic [W-1:0]    rd_data4, rd_data3;
`endif

  pwm_shadow_bank #(.N_CH(N4), .WIDTH(W)) dut4 (
    .clk(clk), .reset(rst4), .wr_en(wr_en4), .wr_ch(wr_ch4), .wr_data(wr_data4),
    .wr_ready(wr_ready4), .arm(arm4), .mask_event(mask4), .lock(lock4),
    .active_out(active4), .pending(pending4), .update_done(done4),
`ifdef PWM_SHADOW_READBACK_EN
    .rd_ch(rd_ch4), .rd_data(rd_data4),
`endif
    .wr_err(err4)
  );

  pwm_shadow_bank #(.N_CH(N3), .WIDTH(W)) dut3 (
    .clk(clk), .reset(rst3), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
    .wr_ready(wr_ready3), .arm(arm3), .mask_event(mask3), .lock(lock3),
    .active_out(active3), .pending(pending3), .update_done(done3),
`ifdef PWM_SHADOW_READBACK_EN
    .rd_ch(rd_ch3), .rd_data(rd_data3),
`endif
    .wr_err(err3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the 4-channel bank: staged values, a pending set and
  // an "armed" flag. Arming needs something already staged before this cycle.
  logic [W-1:0]  m_stage [N4];
  logic [W-1:0]  m_act   [N4];
  logic [N4-1:0] m_pend;
  bit            m_armed, m_done, m_err;
  logic [W-1:0]  m_rd;

  task automatic model_reset();
    for (int i = 0; i < N4; i++) begin
      m_stage[i] = '0;
      m_act[i]   = '0;
    end
    m_pend = '0; m_armed = 0; m_done = 0; m_err = 0; m_rd = '0;
  endtask

  task automatic model_step();
    logic [N4-1:0] pend_before;
    if (!rst4) begin
      model_reset();
      return;
    end
`ifdef PWM_SHADOW_READBACK_EN
    m_rd = m_stage[rd_ch4];
`endif
    pend_before = m_pend;
    m_done = 0;
    if (m_armed) begin
      if (mask4 && !lock4) begin
        for (int i = 0; i < N4; i++) if (m_pend[i]) m_act[i] = m_stage[i];
        m_pend  = '0;
        m_armed = 0;
        m_done  = 1;
      end
    end else begin
      if (wr_en4) begin
        if (int'(wr_ch4) < N4) begin
          m_stage[wr_ch4] = wr_data4;
          m_pend[wr_ch4]  = 1'b1;
        end else begin
          m_err = 1;
        end
      end
      if (arm4 && pend_before != '0) m_armed = 1;
    end
  endtask

  function automatic logic [N4*W-1:0] exp_active();
    logic [N4*W-1:0] v;
    for (int i = 0; i < N4; i++) v[i*W +: W] = m_act[i];
    return v;
  endfunction

  task automatic check_all();
    check("active_out", active4, exp_active());
    check("pending", pending4, m_pend);
    check("wr_ready", wr_ready4, !m_armed);
    check("update_done", done4, m_done);
    check("wr_err", err4, m_err);
`ifdef PWM_SHADOW_READBACK_EN
    check("rd_data", rd_data4, m_rd);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit we, input int ch, input logic [W-1:0] d,
                       input bit a, input bit m, input bit l);
    wr_en4 = we; wr_ch4 = 2'(ch); wr_data4 = d; arm4 = a; mask4 = m; lock4 = l;
    tick();
  endtask

  task automatic idle4();
    drive(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    wr_en4 = 0; wr_ch4 = '0; wr_data4 = '0; arm4 = 0; mask4 = 0; lock4 = 0;
    wr_en3 = 0; wr_ch3 = '0; wr_data3 = '0; arm3 = 0; mask3 = 0; lock3 = 0;
`ifdef PWM_SHADOW_READBACK_EN
    rd_ch4 = '0; rd_ch3 = '0;
`endif
    model_reset();
    #1;
    rst4 = 1'b0; rst3 = 1'b0;
    #1;
    check_all();
    repeat (3) tick();
    check("rst_active", active4, 64'h0);
    check("rst_pending", pending4, 4'h0);
    check("rst_wr_ready", wr_ready4, 1'b1);
    check("rst_update_done", done4, 1'b0);
    rst4 = 1'b1; rst3 = 1'b1;

    // Basic commit
    drive(1, 0, 16'h1234, 0, 0, 0);
    drive(1, 2, 16'h00FF, 0, 0, 0);
    check("basic_pending", pending4, 4'b0101);
    drive(0, 0, '0, 1, 0, 0);
    drive(0, 0, '0, 0, 1, 0);
    check("basic_ch0", active4[15:0], 16'h1234);
    check("basic_ch2", active4[47:32], 16'h00FF);
    check("basic_ch1_ch3", {active4[63:48], active4[31:16]}, 32'h0);
    check("basic_done", done4, 1'b1);
    check("basic_pending_clr", pending4, 4'h0);
    idle4();
    check("basic_done_len", done4, 1'b0);

    // Locked mask_events are ignored
    drive(1, 1, 16'hAAAA, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0, 0, 1, 1);
      check("lock_ch1", active4[31:16], 16'h0);
      check("lock_wr_ready", wr_ready4, 1'b0);
      check("lock_done", done4, 1'b0);
      drive(0, 0, '0, 0, 0, 1);
    end
    drive(0, 0, '0, 0, 1, 0);
    check("unlock_ch1", active4[31:16], 16'hAAAA);

    // arm and mask_event together in STAGING: no commit until the next event
    drive(1, 3, 16'h0101, 0, 0, 0);
    drive(0, 0, '0, 1, 1, 0);
    check("armmask_ch3", active4[63:48], 16'h0);
    check("armmask_done", done4, 1'b0);
    idle4();
    drive(0, 0, '0, 0, 1, 0);
    check("armmask_commit", active4[63:48], 16'h0101);

    // Write while ARMED is dropped
    drive(1, 0, 16'h7777, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0);
    drive(1, 3, 16'h5555, 0, 0, 0);
    check("armed_drop_pend", pending4, 4'b0001);
    drive(0, 0, '0, 0, 1, 0);
    check("armed_drop_ch3", active4[63:48], 16'h0101);
    check("armed_ch0", active4[15:0], 16'h7777);

    // Write in the same cycle as arm is part of the commit
    drive(1, 1, 16'h2222, 0, 0, 0);
    drive(1, 2, 16'h3333, 1, 0, 0);
    drive(0, 0, '0, 0, 1, 0);
    check("wrarm_ch2", active4[47:32], 16'h3333);
    check("wrarm_ch1", active4[31:16], 16'h2222);

    // arm in IDLE is ignored; mask_event in IDLE does nothing
    drive(0, 0, '0, 1, 1, 0);
    check("idle_arm", wr_ready4, 1'b1);

    // Reset while ARMED loses staged data
    drive(1, 0, 16'hBEEF, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0);
    rst4 = 1'b0;
    #1;
    check("midrst_active", active4, 64'h0);
    check("midrst_pending", pending4, 4'h0);
    check("midrst_wr_ready", wr_ready4, 1'b1);
    model_reset();
    idle4();
    rst4 = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
`ifdef PWM_SHADOW_READBACK_EN
      rd_ch4 = 2'($urandom_range(0, 3));
`endif
      drive($urandom_range(0, 1), $urandom_range(0, 3), 16'($urandom),
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3);
    end
    idle4();

    // 3-channel instance: out-of-range write, then reset while ARMED
    wr_en3 = 1; wr_ch3 = 2'd3; wr_data3 = 16'h9999;
    tick();
    wr_en3 = 0;
    check("n3_err", err3, 1'b1);
    check("n3_err_pending", pending3, 3'h0);
    check("n3_err_idle", wr_ready3, 1'b1);
    tick();
    arm3 = 1;
    tick();
    arm3 = 0;
    check("n3_idle_arm", wr_ready3, 1'b1);
    wr_en3 = 1; wr_ch3 = 2'd0; wr_data3 = 16'h0042;
    tick();
    wr_en3 = 0;
    check("n3_pending", pending3, 3'b001);
`ifdef PWM_SHADOW_READBACK_EN
    rd_ch3 = 2'd0;
    tick();
    check("n3_rd_ch0", rd_data3, 16'h0042);
    rd_ch3 = 2'd3;
    tick();
    check("n3_rd_oob", rd_data3, 16'h0);
`endif
    arm3 = 1;
    tick();
    arm3 = 0;
    check("n3_armed", wr_ready3, 1'b0);
    rst3 = 1'b0;
    #1;
    check("n3_rst_active", active3, 48'h0);
    check("n3_rst_err", err3, 1'b0);
    check("n3_rst_pending", pending3, 3'h0);
    check("n3_rst_idle", wr_ready3, 1'b1);
    tick();
    rst3 = 1'b1;
    mask3 = 1;
    tick();
    mask3 = 0;
    check("n3_after_rst_active", active3, 48'h0);
    check("n3_after_rst_done", done3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
